pt_check: RTL and testbench



---
 rtl/pt_check_pkg.sv | 23 ++
 rtl/pt_check.sv | 119 +++++++++++
 tb/tb_pt_check.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pt_check_pkg.sv
// Shared types and helpers for the plaintext capture-and-validate stage.
package pt_check_pkg;

  // Controller states. The encoding is visible on the dbg_state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRLEN  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default printable-ASCII window: space through tilde, both inclusive.
  localparam logic [7:0] PT_PRINT_LO = 8'h20;
  localparam logic [7:0] PT_PRINT_HI = 8'h7E;

  // True when b lies inside the inclusive range [lo, hi].
  function automatic logic is_printable(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_check.sv
// Plaintext capture-and-validate stage. Writes a length-prefixed message into
// the plaintext RAM (length at address 0, bytes at 1..len) and checks every
// byte against the printable range. It aborts on the first bad byte so the key
// search can move on early.
//
// Handshakes: the start request is taken when en && rdy; a data byte is taken
// when in_valid && in_ready. rdy and in_ready depend on state only, so the
// upstream blocks may hold en or in_valid high for as long as they like, and a
// request made while the matching ready is low is simply not seen.
module pt_check
  import pt_check_pkg::*;
#(
  parameter logic [7:0] PRINT_LO = PT_PRINT_LO,
  parameter logic [7:0] PRINT_HI = PT_PRINT_HI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] len,
  output logic       rdy,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       done,
  output logic       ok,
  output logic [7:0] bad_idx,
  output state_t     dbg_state
);

  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic       ok_q;
  logic [7:0] bad_idx_q;
  logic       accept;
  logic       byte_ok;

  assign accept  = in_valid && (state_q == STREAM);
  assign byte_ok = is_printable(in_data, PRINT_LO, PRINT_HI);

  // Controller: captures the length, walks idx over the bytes and records the verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= 8'h00;
      idx_q     <= 8'h00;
      ok_q      <= 1'b0;
      bad_idx_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            len_q     <= len;
            ok_q      <= 1'b0;
            bad_idx_q <= 8'h00;
            idx_q     <= 8'h01;
            state_q   <= WRLEN;
          end
        end
        WRLEN: begin
          if (len_q == 8'h00) begin
            ok_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (in_valid) begin
            if (!byte_ok) begin
              ok_q      <= 1'b0;
              bad_idx_q <= idx_q;
              state_q   <= DONE;
            end else if (idx_q == len_q) begin
              // len is at most 255, so idx never has to pass 255 and cannot wrap.
              ok_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 8'h01;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory write port: the length in WRLEN, otherwise each accepted byte (bad ones included).
  always_comb begin
    pt_wren   = 1'b0;
    pt_addr   = 8'h00;
    pt_wrdata = 8'h00;
    if (state_q == WRLEN) begin
      pt_wren   = 1'b1;
      pt_addr   = 8'h00;
      pt_wrdata = len_q;
    end else if (accept) begin
      pt_wren   = 1'b1;
      pt_addr   = idx_q;
      pt_wrdata = in_data;
    end
  end

  assign rdy       = (state_q == IDLE);
  assign in_ready  = (state_q == STREAM);
  assign done      = (state_q == DONE);
  assign ok        = ok_q;
  assign bad_idx   = bad_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pt_check.sv
// Directed testbench for pt_check with a write/done scoreboard.
module tb_pt_check;
  import pt_check_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] len;
  logic       rdy;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;
  logic       done;
  logic       ok;
  logic [7:0] bad_idx;
  state_t     dbg_state;

  pt_check dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .len       (len),
    .rdy       (rdy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .done      (done),
    .ok        (ok),
    .bad_idx   (bad_idx),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];       // expected writes: {addr, data}
  logic [40:0] exp_done_q[$];  // expected done: {cycle, ok, bad_idx}
  int tests_run = 0;
  int tests_failed = 0;
  int t0 = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: compares every write and every done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (pt_wren) begin
        if (exp_q.size() == 0) check("unexpected_write", {48'h0, pt_addr, pt_wrdata}, 64'hFFFF);
        else check("pt_write", {48'h0, pt_addr, pt_wrdata}, {48'h0, exp_q.pop_front()});
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", {23'h0, 32'(cyc), ok, bad_idx}, 64'hFFFF);
        else check("done_result", {23'h0, 32'(cyc), ok, bad_idx}, {23'h0, exp_done_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue en with the given length; returns at the first STREAM cycle (t0+2).
  task automatic start(input logic [7:0] n);
    en  = 1'b1;
    len = n;
    t0  = cyc;
    @(posedge clk); #1;
    en  = 1'b0;
    len = 8'h00;
    @(posedge clk); #1;
  endtask

  // One byte slot per cycle; v=0 makes it a stall slot.
  task automatic send(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && exp_done_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_done_q.size() != 0) begin
      check("done_timeout", 64'(exp_done_q.size()), 64'h0);
      exp_done_q.delete();
    end
  endtask

  function automatic logic [63:0] outs();
    return {39'h0, rdy, in_ready, pt_wren, pt_addr, pt_wrdata, done, ok, bad_idx};
  endfunction

  localparam logic [63:0] RESET_OUTS = {39'h0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; len = 8'h00; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("reset_outs_initial", outs(), RESET_OUTS);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // len=3 "Hi!" back-to-back: done at cycle 5, ok=1.
    exp_q.push_back({8'h00, 8'h03}); exp_q.push_back({8'h01, 8'h48});
    exp_q.push_back({8'h02, 8'h69}); exp_q.push_back({8'h03, 8'h21});
    start(8'd3);
    exp_done_q.push_back({32'(t0 + 5), 1'b1, 8'h00});
    send(1, 8'h48); send(1, 8'h69); send(1, 8'h21);
    wait_done();

    // Async reset mid-stream: outputs return immediately, ok cleared.
    exp_q.push_back({8'h00, 8'h05}); exp_q.push_back({8'h01, 8'h61});
    exp_q.push_back({8'h02, 8'h62});
    start(8'd5);
    send(1, 8'h61); send(1, 8'h62);
    in_valid = 1'b1; in_data = 8'h63;
    #2 rst = 1'b1;
    #1 check("reset_outs_stream", outs(), RESET_OUTS);
    in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_reset", 64'(rdy), 64'h1);

    // Reset while idle.
    #2 rst = 1'b1;
    #1 check("reset_outs_idle", outs(), RESET_OUTS);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Abort on 0x07 at index 2: done at cycle 4, bad_idx=2, 0x42 not consumed.
    exp_q.push_back({8'h00, 8'h04}); exp_q.push_back({8'h01, 8'h41});
    exp_q.push_back({8'h02, 8'h07});
    start(8'd4);
    exp_done_q.push_back({32'(t0 + 4), 1'b0, 8'h02});
    send(1, 8'h41); send(1, 8'h07); send(1, 8'h42); send(1, 8'h43);
    wait_done();
    check("in_ready_after_abort", 64'(in_ready), 64'h0);

    // Inclusive boundaries accepted.
    exp_q.push_back({8'h00, 8'h02}); exp_q.push_back({8'h01, 8'h20});
    exp_q.push_back({8'h02, 8'h7E});
    start(8'd2);
    exp_done_q.push_back({32'(t0 + 4), 1'b1, 8'h00});
    send(1, 8'h20); send(1, 8'h7E);
    wait_done();

    // Just below the range rejected.
    exp_q.push_back({8'h00, 8'h01}); exp_q.push_back({8'h01, 8'h1F});
    start(8'd1);
    exp_done_q.push_back({32'(t0 + 3), 1'b0, 8'h01});
    send(1, 8'h1F);
    wait_done();

    // Just above the range rejected.
    exp_q.push_back({8'h00, 8'h01}); exp_q.push_back({8'h01, 8'h7F});
    start(8'd1);
    exp_done_q.push_back({32'(t0 + 3), 1'b0, 8'h01});
    send(1, 8'h7F);
    wait_done();

    // len=0: single length write, done at cycle 2 with ok=1.
    exp_q.push_back({8'h00, 8'h00});
    start(8'd0);
    exp_done_q.push_back({32'(t0 + 2), 1'b1, 8'h00});
    wait_done();

    // Stalls 1,0,0,1 with a stray en mid-stream: done at cycle 6.
    exp_q.push_back({8'h00, 8'h02}); exp_q.push_back({8'h01, 8'h41});
    exp_q.push_back({8'h02, 8'h42});
    start(8'd2);
    exp_done_q.push_back({32'(t0 + 6), 1'b1, 8'h00});
    send(1, 8'h41);
    en = 1'b1; len = 8'd7;
    send(0, 8'h55);
    en = 1'b0; len = 8'd0;
    send(0, 8'h00);
    send(1, 8'h42);
    // Now in the DONE cycle; next cycle rdy returns and en is taken at once.
    @(posedge clk); #1;
    check("rdy_after_done", 64'(rdy), 64'h1);
    exp_q.push_back({8'h00, 8'h01}); exp_q.push_back({8'h01, 8'h7E});
    start(8'd1);
    check("ok_cleared_on_en", {55'h0, ok, bad_idx}, 64'h0);
    exp_done_q.push_back({32'(t0 + 3), 1'b1, 8'h00});
    send(1, 8'h7E);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
